// File: rtl/fetch_unit_if.sv
// Shared sizing package and the fetch <-> (imem, decode) bus interface.
// The master modport is the fetch side; slave is the memory/consumer side.
package params_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_SIZE   = 128;
endpackage

interface fetch_unit_if #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_data_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic                  branch_taken_i;
  logic [ADDR_WIDTH-1:0] branch_offset_i;
  logic                  jump_i;
  logic [ADDR_WIDTH-1:0] jump_target_i;
  logic                  fault_o;

  modport master (
    output imem_addr_o, instr_o, pc_o, instr_valid_o, fault_o,
    input  imem_data_i, instr_ready_i, branch_taken_i, branch_offset_i,
           jump_i, jump_target_i
  );

  modport slave (
    input  imem_addr_o, instr_o, pc_o, instr_valid_o, fault_o,
    output imem_data_i, instr_ready_i, branch_taken_i, branch_offset_i,
           jump_i, jump_target_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory in a one-cycle FETCH state, holds the word in VALID until the
// consumer handshakes, then computes the next PC (jump > branch > +1).
// Optional macro FETCH_BOUNDS_CHECK_EN adds a sticky FAULT state entered when
// a fetch address is >= MEM_SIZE.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int                    MEM_SIZE   = params_pkg::MEM_SIZE,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  fetch_unit_if.master bus
);

`ifdef FETCH_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_e;
  localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH+1)'(MEM_SIZE);
`else
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_e;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic                  valid_q, valid_d;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic                  fault_q, fault_d;
`endif

  // Next-state and next-output logic; every register has a hold default.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: if (start_i) state_d = FETCH;
      FETCH: begin
`ifdef FETCH_BOUNDS_CHECK_EN
        // Out-of-range fetch: keep the old instruction/pc and lock up.
        if ({1'b0, pc_q} >= MEM_LIM) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          instr_d = bus.imem_data_i;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = VALID;
        end
`else
        instr_d = bus.imem_data_i;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        state_d = VALID;
`endif
      end
      VALID: begin
        // Redirect inputs are only meaningful in the handshake cycle.
        if (bus.instr_ready_i) begin
          if (bus.jump_i)              pc_d = bus.jump_target_i;
          else if (bus.branch_taken_i) pc_d = ipc_q + bus.branch_offset_i;
          else                         pc_d = ipc_q + 1'b1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset discards any held instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = ipc_q;
  assign bus.instr_valid_o = valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign bus.fault_o       = fault_q;
`else
  assign bus.fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver pushes the expected {pc, instr}
// of the next instruction at each handshake (from a plain PC model and the
// memory table), and a monitor pops/compares whenever a new instruction
// becomes valid.
module tb_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MS = 128;
  localparam logic [AW-1:0] RPC = 16'd1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fif ();

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .RESET_PC(RPC)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .start_i(start),
    .bus   (fif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      16'd1:   return 32'h0000_4470;
      16'd2:   return 32'h0004_0B23;
      16'd8:   return 32'h0009_8DF9;
      16'd71:  return 32'hFFF9_8D69;
      16'd94:  return 32'h0007_800D;
      default: return 32'(a) * 32'd100;
    endcase
  endfunction

  assign fif.imem_data_i = mem_word(fif.imem_addr_o);

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] cur_pc;
  bit            prev_v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a rising instr_valid_o presents a new instruction.
  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (fif.instr_valid_o && !prev_v) begin
        exp_t e;
        chk("sb_pending", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_pc", 64'(fif.pc_o), 64'(e.pc));
          chk("sb_instr", 64'(fif.instr_o), 64'(e.instr));
        end
      end
      prev_v = fif.instr_valid_o;
    end
  end

  task automatic push_exp(input logic [AW-1:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = mem_word(pc);
    q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!fif.instr_valid_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid"}, 64'(fif.instr_valid_o), 64'd1);
  endtask

  // Backpressure: outputs must not move while ready is low.
  task automatic hold(input int d);
    logic [AW-1:0] p0;
    logic [DW-1:0] i0;
    p0 = fif.pc_o;
    i0 = fif.instr_o;
    fif.instr_ready_i = 1'b0;
    for (int c = 0; c < d; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(fif.instr_valid_o), 64'd1);
      chk("bp_pc", 64'(fif.pc_o), 64'(p0));
      chk("bp_instr", 64'(fif.instr_o), 64'(i0));
    end
  endtask

  // One handshake with the given redirect; model picks jump > branch > +1.
  task automatic hs(input bit j, input logic [AW-1:0] tgt, input bit br, input logic [AW-1:0] off);
    logic [AW-1:0] nxt;
    if (j) nxt = tgt;
    else if (br) nxt = cur_pc + off;
    else nxt = cur_pc + 16'd1;
`ifdef FETCH_BOUNDS_CHECK_EN
    if (32'(nxt) < MS) push_exp(nxt);
`else
    push_exp(nxt);
`endif
    cur_pc = nxt;
    fif.instr_ready_i   = 1'b1;
    fif.jump_i          = j;
    fif.jump_target_i   = tgt;
    fif.branch_taken_i  = br;
    fif.branch_offset_i = off;
    @(negedge clk);
    chk("hs_drop", 64'(fif.instr_valid_o), 64'd0);
    fif.instr_ready_i   = 1'b0;
    fif.jump_i          = 1'($urandom);
    fif.jump_target_i   = AW'($urandom);
    fif.branch_taken_i  = 1'($urandom);
    fif.branch_offset_i = AW'($urandom);
  endtask

  // start pulse sampled at edge N: FETCH until N+1, instruction valid after.
  task automatic start_seq();
    cur_pc = RPC;
    push_exp(RPC);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_lat_n", 64'(fif.instr_valid_o), 64'd0);
    @(negedge clk);
    chk("start_lat_n1", 64'(fif.instr_valid_o), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_addr"}, 64'(fif.imem_addr_o), 64'(RPC));
    chk({nm, "_instr"}, 64'(fif.instr_o), 64'd0);
    chk({nm, "_pc"}, 64'(fif.pc_o), 64'd0);
    chk({nm, "_valid"}, 64'(fif.instr_valid_o), 64'd0);
    chk({nm, "_fault"}, 64'(fif.fault_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pc_before;
    rst_n = 1'b0;
    start = 1'b0;
    fif.instr_ready_i   = 1'b0;
    fif.jump_i          = 1'b0;
    fif.jump_target_i   = '0;
    fif.branch_taken_i  = 1'b0;
    fif.branch_offset_i = '0;
    cur_pc = RPC;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("idle");

    // 1. reset and start
    start_seq();

    // 2. backpressure then plain sequential handshake, 2-cycle period
    hold(5);
    hs(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("next_lat", 64'(fif.instr_valid_o), 64'd1);
    while (cur_pc != 16'd8) begin
      wait_valid("seq");
      hs(1'b0, '0, 1'b0, '0);
    end

    // 3. branches forward and backward
    wait_valid("at8");
    hs(1'b0, '0, 1'b1, 16'd63);
    wait_valid("at71");
    hs(1'b0, '0, 1'b1, 16'hFFF6);
    // 4. jump beats branch
    wait_valid("at61");
    hs(1'b1, 16'd94, 1'b1, 16'd5);

    // random redirect mix, always kept in range
    repeat (40) begin
      int r;
      int off;
      int tgt;
      wait_valid("rnd");
      hold(int'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 3));
      if (r == 0 || cur_pc >= 16'd127) begin
        hs(1'b1, AW'($urandom_range(0, 126)), 1'($urandom), AW'($urandom));
      end else if (r == 1) begin
        off = int'($urandom_range(0, 40)) - 20;
        tgt = int'(cur_pc) + off;
        if (tgt >= 0 && tgt < MS) hs(1'b0, AW'($urandom), 1'b1, AW'(off));
        else hs(1'b0, AW'($urandom), 1'b0, AW'(off));
      end else begin
        hs(1'b0, AW'($urandom), 1'b0, AW'($urandom));
      end
    end

    // 5. jump out of range
    wait_valid("pre200");
    pc_before = fif.pc_o;
    hs(1'b1, 16'd200, 1'b0, '0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("fault_early", 64'(fif.fault_o), 64'd0);
    repeat (21) begin
      @(negedge clk);
      chk("fault_set", 64'(fif.fault_o), 64'd1);
      chk("fault_novalid", 64'(fif.instr_valid_o), 64'd0);
      chk("fault_pc_kept", 64'(fif.pc_o), 64'(pc_before));
    end
`else
    wait_valid("at200");
    chk("pc200", 64'(fif.pc_o), 64'd200);
    chk("nofault", 64'(fif.fault_o), 64'd0);
`endif

    // 6. async reset while VALID
    do_reset();
    start_seq();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("post_rst_idle");
    start_seq();
    hs(1'b0, '0, 1'b0, '0);
    wait_valid("final");
    @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
